// File: rtl/draw_number_unit_if.sv
// Pixel query bus for draw_number_unit.
// curr_x/curr_y : pixel being rendered (unsigned)
// pos_x/pos_y   : top-left corner of the number field
// number        : unsigned value to display
// pixel_on      : 1 when the current pixel lies on a lit segment
interface draw_number_unit_if;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [31:0] number;
  logic        pixel_on;

  modport master (
    output curr_x, curr_y, pos_x, pos_y, number,
    input  pixel_on
  );

  modport slave (
    input  curr_x, curr_y, pos_x, pos_y, number,
    output pixel_on
  );
endinterface

// File: rtl/draw_number_unit.sv
// Renders a 32-bit unsigned value as left-justified 7-segment decimal digits
// with leading zeros suppressed. Binary-to-BCD runs sequentially (double
// dabble, one iteration per clock); the pixel lookup is combinational from
// the latched display registers.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : draw_number_unit_if.slave (curr_x/y, pos_x/y, number in; pixel_on out)
module draw_number_unit (
  input  logic              clk,
  input  logic              rst_n,
  draw_number_unit_if.slave bus
);

  localparam int unsigned CELL_W  = 16;
  localparam int unsigned CELL_H  = 24;
  localparam int unsigned CELL_SH = $clog2(CELL_W);
  localparam int unsigned NUM_W   = 32;
  localparam int unsigned NDIG    = 10;
  localparam int unsigned BCD_W   = 4 * NDIG;
  localparam int unsigned SR_W    = BCD_W + NUM_W;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_start;
  logic [NUM_W-1:0]      r_last_num;
  logic [SR_W-1:0]       r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [NDIG-1:0][3:0]  r_disp_dig;
  logic [3:0]            r_disp_n;
  logic [NDIG-1:0][3:0]  w_bcd;
  logic [3:0]            w_bcd_n;

  // One double-dabble iteration: correct nibbles >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (t[NUM_W + 4*k +: 4] >= 4'd5)
        t[NUM_W + 4*k +: 4] = t[NUM_W + 4*k +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Digit count = position of the highest non-zero digit, at least 1.
  function automatic logic [3:0] digit_count(input logic [NDIG-1:0][3:0] d);
    logic [3:0] n;
    n = 4'd1;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (d[k] != 4'd0) n = 4'(k + 1);
    end
    return n;
  endfunction

  // Segment mask {a,b,c,d,e,f,g} for a decimal digit.
  function automatic logic [6:0] seg_lit(input logic [3:0] d);
    logic [6:0] m;
    case (d)
      4'd0:    m = 7'b1111110;
      4'd1:    m = 7'b0110000;
      4'd2:    m = 7'b1101101;
      4'd3:    m = 7'b1111001;
      4'd4:    m = 7'b0110011;
      4'd5:    m = 7'b1011011;
      4'd6:    m = 7'b1011111;
      4'd7:    m = 7'b1110000;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1111011;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

  assign w_bcd   = r_shift[SR_W-1 -: BCD_W];
  assign w_bcd_n = digit_count(w_bcd);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a new value is only picked up from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.number != r_last_num) begin
          w_start     = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        if (r_cnt == CNT_W'(NUM_W - 1)) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Conversion datapath and display registers (updated in one clock in DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_num <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_disp_dig <= '0;
      r_disp_n   <= 4'd1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shift    <= {BCD_W'(0), bus.number};
            r_last_num <= bus.number;
            r_cnt      <= '0;
          end
        end
        CONV: begin
          r_shift <= dabble_step(r_shift);
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_disp_dig <= w_bcd;
          r_disp_n   <= w_bcd_n;
        end
        default: ;
      endcase
    end
  end

  // Pixel lookup. Differences are taken one bit wider than the coordinates
  // and gated by explicit >= checks so a field near the edge never wraps.
  logic [11:0] w_dx;
  logic [10:0] w_dy;
  logic        w_x_ok;
  logic        w_y_ok;
  logic [7:0]  w_cell;
  logic        w_in_cell;
  logic [3:0]  w_k;
  logic [3:0]  w_digit;
  logic [3:0]  w_lx;
  logic [4:0]  w_ly;
  logic [6:0]  w_seg_hit;

  assign w_dx      = 12'(bus.curr_x) - 12'(bus.pos_x);
  assign w_dy      = 11'(bus.curr_y) - 11'(bus.pos_y);
  assign w_x_ok    = bus.curr_x >= bus.pos_x;
  assign w_y_ok    = (bus.curr_y >= bus.pos_y) && (w_dy < 11'(CELL_H));
  assign w_cell    = 8'(w_dx >> CELL_SH);
  assign w_in_cell = w_cell < 8'(r_disp_n);
  // Cell 0 is the most significant shown digit, i.e. BCD index n-1.
  assign w_k       = 4'(r_disp_n - 4'(w_cell) - 4'd1);
  assign w_lx      = w_dx[3:0];
  assign w_ly      = w_dy[4:0];

  always_comb begin
    w_digit = 4'd0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (w_k == 4'(k)) w_digit = r_disp_dig[k];
    end
  end

  // Segment boxes in cell-local coordinates; cols 12-15 / rows 21-23 never hit.
  always_comb begin
    w_seg_hit    = 7'b0;
    w_seg_hit[6] = (w_lx <= 4'd11) && (w_ly <= 5'd2);                       // a
    w_seg_hit[5] = (w_lx >= 4'd9) && (w_lx <= 4'd11) && (w_ly <= 5'd10);    // b
    w_seg_hit[4] = (w_lx >= 4'd9) && (w_lx <= 4'd11) &&
                   (w_ly >= 5'd10) && (w_ly <= 5'd20);                      // c
    w_seg_hit[3] = (w_lx <= 4'd11) && (w_ly >= 5'd18) && (w_ly <= 5'd20);   // d
    w_seg_hit[2] = (w_lx <= 4'd2) && (w_ly >= 5'd10) && (w_ly <= 5'd20);    // e
    w_seg_hit[1] = (w_lx <= 4'd2) && (w_ly <= 5'd10);                       // f
    w_seg_hit[0] = (w_lx <= 4'd11) && (w_ly >= 5'd9) && (w_ly <= 5'd11);    // g
  end

  assign bus.pixel_on = w_x_ok && w_y_ok && w_in_cell &&
                        (|(w_seg_hit & seg_lit(w_digit)));

endmodule

// File: tb/tb_draw_number_unit.sv
// Directed self-checking bench for draw_number_unit.
module tb_draw_number_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  draw_number_unit_if u_if ();

  draw_number_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Probe one pixel and return pixel_on after settling.
  task automatic pix(input logic [10:0] x, input logic [9:0] y, output logic v);
    u_if.curr_x = x;
    u_if.curr_y = y;
    #1;
    v = u_if.pixel_on;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic v;
    // During reset: renders "0"
    pix(11'd100, 10'd200, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL rst_a got=%b exp=1", v); end
    pix(11'd104, 10'd210, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL rst_g got=%b exp=0", v); end
    pix(11'd116, 10'd200, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL rst_cell1 got=%b exp=0", v); end
    rst_n = 1'b1;
    repeat (3) next_edge();
    pix(11'd100, 10'd200, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL post_rst_a got=%b exp=1", v); end
    pix(11'd104, 10'd210, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL post_rst_g got=%b exp=0", v); end
  endtask

  task automatic test_latency();
    logic v;
    u_if.number = 32'd8;            // sampled at the next edge N
    for (int k = 0; k <= 33; k++) begin
      next_edge();                  // edge N+k
      pix(11'd104, 10'd210, v);
      total++;
      if (v !== ((k <= 32) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL latency_k%0d got=%b exp=%b", k, v, (k <= 32) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_big();
    logic v;
    u_if.number = 32'd1234567890;
    repeat (34) next_edge();
    pix(11'd100, 10'd201, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL big_d1_a got=%b exp=0", v); end
    pix(11'd110, 10'd201, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL big_d1_b got=%b exp=1", v); end
    pix(11'd244, 10'd200, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL big_d9_a got=%b exp=1", v); end
    pix(11'd260, 10'd201, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL big_beyond got=%b exp=0", v); end
    pix(11'd117, 10'd210, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL big_d2_e got=%b exp=1", v); end
    pix(11'd148, 10'd200, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL big_d4_f got=%b exp=1", v); end
    pix(11'd148, 10'd220, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL big_d4_de got=%b exp=0", v); end
  endtask

  // Signature probes: "1234567890"=011, "5"=100, "77"=010.
  task automatic sig(output logic [2:0] s);
    logic a, b, c;
    pix(11'd100, 10'd210, a);
    pix(11'd116, 10'd200, b);
    pix(11'd132, 10'd200, c);
    s = {a, b, c};
  endtask

  task automatic test_change_during_conv();
    logic [2:0] s;
    logic [2:0] e;
    u_if.number = 32'd5;            // sampled at the next edge N
    for (int k = 0; k <= 70; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) u_if.number = 32'd77;
      sig(s);
      if (k <= 32)      e = 3'b011;
      else if (k <= 66) e = 3'b100;
      else              e = 3'b010;
      total++;
      if (s !== e) begin bad++; $display("FAIL change_k%0d got=%b exp=%b", k, s, e); end
    end
  endtask

  task automatic test_max();
    logic v;
    u_if.number = 32'd4294967295;
    repeat (34) next_edge();
    pix(11'd100, 10'd200, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL max_d0_f got=%b exp=1", v); end
    pix(11'd104, 10'd200, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL max_d0_a got=%b exp=0", v); end
    pix(11'd244, 10'd200, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL max_d9_a got=%b exp=1", v); end
    pix(11'd259, 10'd200, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL max_d9_col15 got=%b exp=0", v); end
    pix(11'd260, 10'd200, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL max_beyond got=%b exp=0", v); end
  endtask

  task automatic test_out_of_range();
    logic v;
    pix(11'd111, 10'd205, v);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL oor_inside got=%b exp=1", v); end
    pix(11'd112, 10'd205, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_col12 got=%b exp=0", v); end
    pix(11'd99, 10'd200, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_x99 got=%b exp=0", v); end
    pix(11'd100, 10'd199, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_y199 got=%b exp=0", v); end
    pix(11'd100, 10'd224, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_y224 got=%b exp=0", v); end
    pix(11'd100, 10'd223, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_row23 got=%b exp=0", v); end
    u_if.pos_x = 11'd2040;
    pix(11'd5, 10'd200, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_wrapx5 got=%b exp=0", v); end
    pix(11'd8, 10'd200, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_wrapx8 got=%b exp=0", v); end
    u_if.pos_x = 11'd100;
    u_if.pos_y = 10'd1020;
    pix(11'd100, 10'd5, v);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL oor_wrapy got=%b exp=0", v); end
    u_if.pos_y = 10'd200;
  endtask

  task automatic test_reset_mid_conv();
    logic a, b;
    u_if.number = 32'd999;
    repeat (10) next_edge();        // conversion in flight
    rst_n = 1'b0;
    #1;
    pix(11'd104, 10'd210, a);
    pix(11'd132, 10'd200, b);
    total++; if ({a, b} !== 2'b00) begin bad++; $display("FAIL midrst_zero got=%b exp=00", {a, b}); end
    pix(11'd100, 10'd200, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL midrst_a got=%b exp=1", a); end
    next_edge();
    rst_n = 1'b1;                   // next edge R starts a fresh conversion
    for (int k = 0; k <= 33; k++) begin
      next_edge();
      pix(11'd104, 10'd210, a);
      pix(11'd132, 10'd200, b);
      if (k == 32 || k == 33) begin
        total++;
        if ({a, b} !== ((k == 32) ? 2'b00 : 2'b11)) begin
          bad++; $display("FAIL midrst_k%0d got=%b exp=%b", k, {a, b}, (k == 32) ? 2'b00 : 2'b11);
        end
      end
    end
    pix(11'd148, 10'd200, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL midrst_ndig got=%b exp=0", a); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    u_if.curr_x = 11'd0;
    u_if.curr_y = 10'd0;
    u_if.pos_x  = 11'd100;
    u_if.pos_y  = 10'd200;
    u_if.number = 32'd0;
    repeat (3) next_edge();
    test_reset();
    test_latency();
    test_big();
    test_change_during_conv();
    test_max();
    test_out_of_range();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_number_unit.md
DRAW_NUMBER_UNIT -- requirements
Module: draw_number

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk, input, 1 bit: single clock; all state updates on the rising edge.
- rst_n, input, 1 bit: asynchronous, active-low reset.
- curr_x, input, 11 bits: current pixel column, unsigned.
- curr_y, input, 10 bits: current pixel row, unsigned.
- pos_x, input, 11 bits: left edge of the number field.
- pos_y, input, 10 bits: top edge of the number field.
- number, input, 32 bits: unsigned value to display.
- pixel_on, output, 1 bit: 1 when the current pixel lies on a lit digit segment.

REQ-002 Geometry constants SHALL be CELL_W=16 and CELL_H=24; these are localparams, not overridable.

Function
REQ-003 The block SHALL display number in decimal, left-justified at pos_x, with leading zeros suppressed.
- The digit count n is 1..10; value 0 shows a single "0".

REQ-004 Digit cell i (i=0 is the most significant shown digit, i<n) SHALL occupy:
- x in [pos_x+16i, pos_x+16i+16)
- y in [pos_y, pos_y+24)
- Local coordinates: lx = curr_x-pos_x-16i, ly = curr_y-pos_y.

REQ-005 Segments SHALL be these inclusive boxes in (lx, ly):
- a: lx 0-11, ly 0-2
- b: lx 9-11, ly 0-10
- c: lx 9-11, ly 10-20
- d: lx 0-11, ly 18-20
- e: lx 0-2, ly 10-20
- f: lx 0-2, ly 0-10
- g: lx 0-11, ly 9-11
- Columns 12-15 and rows 21-23 are always dark.

REQ-006 Lit segments per digit SHALL be:
- 0: abcdef
- 1: bc
- 2: abdeg
- 3: abcdg
- 4: bcfg
- 5: acdfg
- 6: acdefg
- 7: abc
- 8: abcdefg
- 9: abcdfg

REQ-007 pixel_on SHALL be combinational from curr_x, curr_y, pos_x, pos_y and the display registers, with zero-cycle latency.
- pixel_on=0 outside all n cells.
- pixel_on=0 when curr_x<pos_x or curr_y<pos_y; comparisons use 12-bit or wider arithmetic, with no wrap-around.

REQ-008 Binary-to-BCD conversion SHALL be sequential shift-add-3 (double-dabble) with FSM states IDLE, CONV and DONE.
- IDLE: if number != last_num, capture number into the shift register, set last_num <= number, clear the iteration counter, go to CONV.
- CONV: perform one iteration per clock (add 3 to each BCD nibble >=5, then shift left 1); after the 32nd iteration go to DONE.
- DONE: copy the 10 BCD digits and the computed n into the display registers in one clock, then go to IDLE.

REQ-009 Latency: a value captured at rising edge N SHALL become visible on pixel_on after edge N+33 and not before.
- The display registers hold the previous value, unchanged, through edge N+32.

REQ-010 A change to number during CONV or DONE SHALL be ignored until IDLE is re-entered; it is then detected and converted.
- Only the final stable value is guaranteed to be displayed.

REQ-011 The display registers SHALL update atomically, so no partially converted digits are ever visible.

REQ-012 number = 4294967295 SHALL display 10 digits "4294967295" spanning x in [pos_x, pos_x+160).

Reset
REQ-013 While rst_n=0 the block SHALL force these values asynchronously:
- state=IDLE, last_num=0
- all display digits=0, n=1
- shift register and counter cleared
- pixel_on therefore renders "0".

REQ-014 Reset asserted mid-conversion SHALL abort the conversion.
- After release, if number != 0, a fresh conversion starts on the first clock.

Verification
REQ-015 Scenarios, with pos=(100,200):
- Reset, number=0: (100,200)->1 (segment a); (104,210)->0 (g is off for "0"); (116,200)->0 (no second cell).
- number=8 sampled at edge N: (104,210) reads 0 through edge N+32 and 1 after edge N+33.
- number=1234567890 after 34 clocks:
  - (100,201)->0 ('1' has no a/f); (110,201)->1 ('1' segment b).
  - (244,200)->1 (digit 9 '0', segment a); (260,201)->0 (beyond the field).
- number changes 5->77 during CONV: the display shows 5, then 77; no other value ever appears; the final n=2.
- Out-of-range coordinates: curr_x=99 or curr_y=199 or curr_y=224 -> 0; pos_x=2040 with curr_x=5 -> 0 (no wrap).
- rst_n pulsed low mid-conversion of 999: pixel_on immediately renders "0"; after release, "999" appears 34 clocks later.
